// File: rtl/fetch_stall_ctrl_pkg.sv
// Shared fetch-pipeline definitions: NOP encoding, reset PC and fetch FSM states.
// The state enum is also decoded by the ID-stage debug monitor.
package fetch_stall_ctrl_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  // A redirect outranks a stall: the stalled instruction is flushed anyway.
  function automatic fetch_state_e fetch_next_state(input logic branch_taken,
                                                    input logic stall);
    fetch_state_e nxt;
    nxt = ST_RUN;
    if (branch_taken) begin
      nxt = ST_FLUSH;
    end else if (stall) begin
      nxt = ST_HOLD;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Stall watchdog: counts consecutive stall cycles, raises a sticky error once the
// run reaches STALL_MAX, and keeps a saturating total of stalled cycles.
module stall_watchdog #(
  parameter int STALL_MAX = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  output logic             stall_err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int               RUN_W    = $clog2(STALL_MAX + 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STALL_MAX);
  localparam logic [RUN_W-1:0] RUN_TRIP = RUN_W'(STALL_MAX - 1);

  logic [RUN_W-1:0] run_len_q, run_len_d;
  logic             stall_err_q, stall_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    run_len_d   = run_len_q;
    stall_err_d = stall_err_q;
    stall_cnt_d = stall_cnt_q;

    if (!stall_i) begin
      run_len_d = '0;
    end else if (run_len_q != RUN_MAX) begin
      run_len_d = run_len_q + RUN_W'(1);
    end

    // Trip on the edge that completes the STALL_MAX-th consecutive stall cycle.
    if (stall_i && (run_len_q >= RUN_TRIP)) begin
      stall_err_d = 1'b1;
    end

    if (stall_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_len_q   <= '0;
      stall_err_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      run_len_q   <= run_len_d;
      stall_err_q <= stall_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_err_o = stall_err_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: rtl/fetch_stall_ctrl.sv
// Fetch stage: PC and IF/ID register under hazard-unit stall/PCWrite/IFWrite control,
// taken-branch redirect with IF/ID flush, combinational ID/EX bubble, watchdog and counters.
module fetch_stall_ctrl
  import fetch_stall_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          STALL_MAX = 8,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             PCWrite,
  input  logic             IFWrite,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      pc,
  output logic [31:0]      IF_Instr,
  output logic [31:0]      IF_PC4,
  output logic             IF_Valid,
  output logic             bubble,
  output logic             stall_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      if_instr_q, if_instr_d;
  logic [31:0]      if_pc4_q, if_pc4_d;
  logic             if_valid_q, if_valid_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [31:0]      pc_plus4;
  fetch_state_e     state_q;

  assign pc_plus4 = pc_q + INSTR_BYTES;

  // Hazard inputs act independently: a stall with PCWrite=1 still advances the PC.
  always_comb begin
    pc_d        = pc_q;
    if_instr_d  = if_instr_q;
    if_pc4_d    = if_pc4_q;
    if_valid_d  = if_valid_q;
    flush_cnt_d = flush_cnt_q;

    if (branch_taken) begin
      pc_d = branch_target;
    end else if (PCWrite) begin
      pc_d = pc_plus4;
    end

    if (branch_taken) begin
      if_instr_d = NOP_INSTR;
      if_valid_d = 1'b0;
    end else if (IFWrite) begin
      if_instr_d = imem_rdata;
      if_pc4_d   = pc_plus4;
      if_valid_d = 1'b1;
    end

    if (branch_taken && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      if_instr_q  <= NOP_INSTR;
      if_pc4_q    <= '0;
      if_valid_q  <= 1'b0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      if_instr_q  <= if_instr_d;
      if_pc4_q    <= if_pc4_d;
      if_valid_q  <= if_valid_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= fetch_next_state(branch_taken, stall);
    end
  end

  // FLUSH means the last edge was a redirect, so IF/ID must hold a bubble.
  always_comb begin
    if (rst_n && (state_q == ST_FLUSH)) begin
      assert (!if_valid_q);
    end
  end

  stall_watchdog #(
    .STALL_MAX (STALL_MAX),
    .CNT_W     (CNT_W)
  ) u_watchdog (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_i     (stall),
    .stall_err_o (stall_err),
    .stall_cnt_o (stall_cnt)
  );

  assign bubble    = stall | branch_taken;
  assign pc        = pc_q;
  assign IF_Instr  = if_instr_q;
  assign IF_PC4    = if_pc4_q;
  assign IF_Valid  = if_valid_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Directed bench for fetch_stall_ctrl: vector table plus watchdog, reset and wrap sequences.
module tb_fetch_stall_ctrl;
  import fetch_stall_ctrl_pkg::*;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall, pc_write, if_write, branch_taken;
  logic [31:0]   branch_target, imem_rdata;
  logic [31:0]   pc, if_instr, if_pc4;
  logic          if_valid, bubble, stall_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Instruction memory model: the word at address A reads as A + 0x1000_0000.
  assign imem_rdata = pc + 32'h1000_0000;

  fetch_stall_ctrl #(.CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .PCWrite       (pc_write),
    .IFWrite       (if_write),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_rdata    (imem_rdata),
    .pc            (pc),
    .IF_Instr      (if_instr),
    .IF_PC4        (if_pc4),
    .IF_Valid      (if_valid),
    .bubble        (bubble),
    .stall_err     (stall_err),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  typedef struct {
    logic          stall, pcw, ifw, br;
    logic [31:0]   tgt;
    logic          bub;
    logic [31:0]   pc, instr, pc4;
    logic          vld;
    logic [CW-1:0] scnt, fcnt;
    fetch_state_e  st;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic pw, input logic iw, input logic b,
                       input logic [31:0] t);
    stall = s; pc_write = pw; if_write = iw; branch_taken = b; branch_target = t;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i);
    drive(vecs[i].stall, vecs[i].pcw, vecs[i].ifw, vecs[i].br, vecs[i].tgt);
    #1;
    chk($sformatf("v%0d bubble", i), 32'(bubble), 32'(vecs[i].bub));
    step();
    chk($sformatf("v%0d pc", i), pc, vecs[i].pc);
    chk($sformatf("v%0d IF_Instr", i), if_instr, vecs[i].instr);
    chk($sformatf("v%0d IF_PC4", i), if_pc4, vecs[i].pc4);
    chk($sformatf("v%0d IF_Valid", i), 32'(if_valid), 32'(vecs[i].vld));
    chk($sformatf("v%0d stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].scnt));
    chk($sformatf("v%0d flush_cnt", i), 32'(flush_cnt), 32'(vecs[i].fcnt));
    chk($sformatf("v%0d stall_err", i), 32'(stall_err), 32'd0);
    chk($sformatf("v%0d state", i), 32'(dut.state_q), 32'(vecs[i].st));
  endtask

  initial begin
    // stall pcw ifw br tgt | bubble pc instr pc4 valid scnt fcnt state
    vecs[0]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,   1'b0,32'h004,32'h1000_0000,32'h004,1'b1,8'd0,8'd0,ST_RUN};
    vecs[1]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,   1'b0,32'h008,32'h1000_0004,32'h008,1'b1,8'd0,8'd0,ST_RUN};
    vecs[2]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,   1'b0,32'h00C,32'h1000_0008,32'h00C,1'b1,8'd0,8'd0,ST_RUN};
    vecs[3]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,   1'b0,32'h010,32'h1000_000C,32'h010,1'b1,8'd0,8'd0,ST_RUN};
    vecs[4]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,   1'b1,32'h010,32'h1000_000C,32'h010,1'b1,8'd1,8'd0,ST_HOLD};
    vecs[5]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,   1'b0,32'h014,32'h1000_0010,32'h014,1'b1,8'd1,8'd0,ST_RUN};
    vecs[6]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,   1'b0,32'h018,32'h1000_0014,32'h018,1'b1,8'd1,8'd0,ST_RUN};
    vecs[7]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,   1'b0,32'h01C,32'h1000_0018,32'h01C,1'b1,8'd1,8'd0,ST_RUN};
    vecs[8]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,   1'b0,32'h020,32'h1000_001C,32'h020,1'b1,8'd1,8'd0,ST_RUN};
    vecs[9]  = '{1'b0,1'b1,1'b1,1'b1,32'h100, 1'b1,32'h100,32'h0000_0000,32'h020,1'b0,8'd1,8'd1,ST_FLUSH};
    vecs[10] = '{1'b0,1'b1,1'b1,1'b0,32'h0,   1'b0,32'h104,32'h1000_0100,32'h104,1'b1,8'd1,8'd1,ST_RUN};
    vecs[11] = '{1'b1,1'b0,1'b0,1'b1,32'h200, 1'b1,32'h200,32'h0000_0000,32'h104,1'b0,8'd2,8'd2,ST_FLUSH};
    vecs[12] = '{1'b0,1'b1,1'b1,1'b0,32'h0,   1'b0,32'h204,32'h1000_0200,32'h204,1'b1,8'd2,8'd2,ST_RUN};
    vecs[13] = '{1'b1,1'b1,1'b0,1'b0,32'h0,   1'b1,32'h208,32'h1000_0200,32'h204,1'b1,8'd3,8'd2,ST_HOLD};
    vecs[14] = '{1'b0,1'b0,1'b1,1'b0,32'h0,   1'b0,32'h208,32'h1000_0208,32'h20C,1'b1,8'd3,8'd2,ST_RUN};
    vecs[15] = '{1'b0,1'b1,1'b1,1'b0,32'h0,   1'b0,32'h20C,32'h1000_0208,32'h20C,1'b1,8'd3,8'd2,ST_RUN};

    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    chk("reset pc", pc, 32'h0);
    chk("reset IF_Instr", if_instr, 32'h0);
    chk("reset IF_PC4", if_pc4, 32'h0);
    chk("reset IF_Valid", 32'(if_valid), 32'd0);
    chk("reset bubble", 32'(bubble), 32'd0);
    chk("reset stall_err", 32'(stall_err), 32'd0);
    chk("reset stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset flush_cnt", 32'(flush_cnt), 32'd0);
    chk("reset state", 32'(dut.state_q), 32'(ST_RUN));
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) run_vec(i);

    // Watchdog: a 7-cycle run must not trip, an 8-cycle run must.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (7) step();
    chk("wd run7 stall_err", 32'(stall_err), 32'd0);
    chk("wd run7 stall_cnt", 32'(stall_cnt), 32'd10);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    step();
    chk("wd gap stall_err", 32'(stall_err), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (7) step();
    chk("wd run8 at7 stall_err", 32'(stall_err), 32'd0);
    step();
    chk("wd run8 at8 stall_err", 32'(stall_err), 32'd1);
    chk("wd run8 stall_cnt", 32'(stall_cnt), 32'd18);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    repeat (3) step();
    chk("wd sticky stall_err", 32'(stall_err), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("wd reset stall_err", 32'(stall_err), 32'd0);
    chk("wd reset stall_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted in the middle of a stalled redirect.
    step();
    chk("pre pc", pc, 32'h4);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h300);
    step();
    chk("redir pc", pc, 32'h300);
    chk("redir flush_cnt", 32'(flush_cnt), 32'd1);
    chk("redir stall_cnt", 32'(stall_cnt), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst pc", pc, 32'h0);
    chk("midrst IF_Instr", if_instr, 32'h0);
    chk("midrst IF_Valid", 32'(if_valid), 32'd0);
    chk("midrst stall_cnt", 32'(stall_cnt), 32'd0);
    chk("midrst flush_cnt", 32'(flush_cnt), 32'd0);
    chk("midrst state", 32'(dut.state_q), 32'(ST_RUN));
    chk("midrst bubble", 32'(bubble), 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    rst_n = 1'b1;
    step();
    chk("post-rst pc", pc, 32'h4);
    chk("post-rst IF_Instr", if_instr, 32'h1000_0000);
    chk("post-rst IF_Valid", 32'(if_valid), 32'd1);

    // PC wrap at the top of the address space.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    step();
    chk("wrap setup pc", pc, 32'hFFFF_FFFC);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    step();
    chk("wrap pc", pc, 32'h0);
    chk("wrap IF_PC4", if_pc4, 32'h0);
    chk("wrap IF_Instr", if_instr, 32'h0FFF_FFFC);

    // Counter saturation.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (260) step();
    chk("sat stall_cnt", 32'(stall_cnt), 32'hFF);
    chk("sat stall_err", 32'(stall_err), 32'd1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h400);
    repeat (260) step();
    chk("sat flush_cnt", 32'(flush_cnt), 32'hFF);
    chk("sat stall_cnt hold", 32'(stall_cnt), 32'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
